// File: rtl/muldiv_unit.sv
// RV32M multiply/divide execution unit: two-cycle multiplier, 32-step restoring
// divider, one operation in flight, result held until writeback accepts it.
module muldiv_unit #(
   parameter int TAG_W = 6
) (
   input  logic             cpu_clock_i,
   input  logic             cpu_reset_i,
   input  logic             flush_i,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic [6:0]       req_uop_i,
   input  logic [31:0]      req_rs1_i,
   input  logic [31:0]      req_rs2_i,
   input  logic [TAG_W-1:0] req_tag_i,
   output logic             res_valid_o,
   input  logic             res_ready_i,
   output logic [31:0]      res_data_o,
   output logic [TAG_W-1:0] res_tag_o
);

   typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_e;

   typedef struct packed {
      logic [2:0]       uop;
      logic [TAG_W-1:0] tag;
      logic             qneg;
      logic             rneg;
   } ctx_t;

   state_e      state_q, state_d;
   ctx_t        ctx_q, ctx_d;
   logic [31:0] a_q, a_d;      // multiplicand, or dividend shifting into quotient
   logic [31:0] b_q, b_d;      // multiplier, or divisor magnitude
   logic [31:0] rem_q, rem_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [31:0] res_q, res_d;
   logic        vld_q, vld_d;

   logic        accept;
   logic        req_signed, req_is_rem, div0, ovf;
   logic [31:0] abs_a, abs_b, special_res;
   logic        sext_a, sext_b;
   logic signed [65:0] ma, mb, prod;
   logic [32:0] r_sh, sub;
   logic        unused_bits;

   assign req_ready_o = (state_q == S_IDLE) && !cpu_reset_i;
   assign accept      = req_valid_i && req_ready_o && !flush_i;

   // Odd divide uops (DIVU, REMU) are unsigned; bit 1 selects remainder.
   assign req_signed  = !req_uop_i[0];
   assign req_is_rem  = req_uop_i[1];
   assign abs_a       = (req_signed && req_rs1_i[31]) ? (32'd0 - req_rs1_i) : req_rs1_i;
   assign abs_b       = (req_signed && req_rs2_i[31]) ? (32'd0 - req_rs2_i) : req_rs2_i;
   assign div0        = (req_rs2_i == 32'd0);
   assign ovf         = req_signed && (req_rs1_i == 32'h8000_0000) && (req_rs2_i == 32'hFFFF_FFFF);

   always_comb begin
      special_res = 32'd0;
      if (div0)
         special_res = req_is_rem ? req_rs1_i : 32'hFFFF_FFFF;
      else if (ovf)
         special_res = req_is_rem ? 32'd0 : 32'h8000_0000;
   end

   // rs1 is sign-extended except for MULHU; rs2 only for MUL and MULH.
   assign sext_a = (ctx_q.uop[1:0] != 2'd3);
   assign sext_b = !ctx_q.uop[1];
   assign ma     = {{34{sext_a & a_q[31]}}, a_q};
   assign mb     = {{34{sext_b & b_q[31]}}, b_q};
   assign prod   = ma * mb;

   assign r_sh = {rem_q, a_q[31]};
   assign sub  = r_sh - {1'b0, b_q};

   assign unused_bits = ^{req_uop_i[6:3], prod[65:64]};

   always_comb begin
      state_d = state_q;
      ctx_d   = ctx_q;
      a_d     = a_q;
      b_d     = b_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               ctx_d.uop  = req_uop_i[2:0];
               ctx_d.tag  = req_tag_i;
               ctx_d.qneg = 1'b0;
               ctx_d.rneg = 1'b0;
               if (!req_uop_i[2]) begin
                  a_d     = req_rs1_i;
                  b_d     = req_rs2_i;
                  state_d = S_MUL;
               end else if (div0 || ovf) begin
                  res_d   = special_res;
                  state_d = S_DONE;
               end else begin
                  a_d        = abs_a;
                  b_d        = abs_b;
                  rem_d      = 32'd0;
                  cnt_d      = 6'd0;
                  ctx_d.qneg = req_signed && (req_rs1_i[31] ^ req_rs2_i[31]);
                  ctx_d.rneg = req_signed && req_rs1_i[31];
                  state_d    = S_DIV;
               end
            end
         end
         S_MUL: begin
            res_d   = (ctx_q.uop[1:0] == 2'd0) ? prod[31:0] : prod[63:32];
            state_d = S_DONE;
         end
         S_DIV: begin
            a_d   = {a_q[30:0], !sub[32]};
            rem_d = sub[32] ? r_sh[31:0] : sub[31:0];
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd31)
               state_d = S_FIX;
         end
         S_FIX: begin
            if (ctx_q.uop[1])
               res_d = ctx_q.rneg ? (32'd0 - rem_q) : rem_q;
            else
               res_d = ctx_q.qneg ? (32'd0 - a_q) : a_q;
            state_d = S_DONE;
         end
         S_DONE: begin
            if (res_ready_i)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (flush_i)
         state_d = S_IDLE;
   end

   assign vld_d = (state_d == S_DONE);

   always_ff @(posedge cpu_clock_i) begin
      if (cpu_reset_i) begin
         state_q <= S_IDLE;
         ctx_q   <= '0;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         rem_q   <= 32'd0;
         cnt_q   <= 6'd0;
         res_q   <= 32'd0;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ctx_q   <= ctx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         vld_q   <= vld_d;
      end
   end

   assign res_valid_o = vld_q;
   assign res_data_o  = res_q;
   assign res_tag_o   = ctx_q.tag;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: results, latency, tags, backpressure,
// flush and reset behaviour against hand-computed values.
module tb_muldiv_unit;
   localparam int TAG_W = 6;

   logic             clk = 1'b0;
   logic             rst;
   logic             flush;
   logic             req_valid;
   logic             req_ready;
   logic [6:0]       req_uop;
   logic [31:0]      rs1, rs2;
   logic [TAG_W-1:0] req_tag;
   logic             res_valid;
   logic             res_ready;
   logic [31:0]      res_data;
   logic [TAG_W-1:0] res_tag;

   int total = 0;
   int bad   = 0;

   muldiv_unit #(.TAG_W(TAG_W)) dut (
      .cpu_clock_i (clk),
      .cpu_reset_i (rst),
      .flush_i     (flush),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_uop_i   (req_uop),
      .req_rs1_i   (rs1),
      .req_rs2_i   (rs2),
      .req_tag_i   (req_tag),
      .res_valid_o (res_valid),
      .res_ready_i (res_ready),
      .res_data_o  (res_data),
      .res_tag_o   (res_tag)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one request for one edge; returns in cycle N+1.
   task automatic issue(input logic [2:0] uop, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] tag);
      req_valid = 1'b1;
      req_uop   = {4'b1010, uop};
      rs1       = a;
      rs2       = b;
      req_tag   = tag;
      tick();
      req_valid = 1'b0;
      req_uop   = 7'd0;
   endtask

   // Waits for res_valid; lat is the cycle offset from the accept cycle N.
   task automatic wait_valid(output int lat);
      lat = 1;
      while (!res_valid && lat < 100) begin
         tick();
         lat++;
      end
   endtask

   task automatic run_op(input string name, input logic [2:0] uop, input logic [31:0] a,
                         input logic [31:0] b, input logic [TAG_W-1:0] tag,
                         input logic [31:0] exp, input int exp_lat);
      int lat;
      chk({name, "_ready"}, req_ready, 1'b1);
      issue(uop, a, b, tag);
      wait_valid(lat);
      chk({name, "_lat"}, lat, exp_lat);
      chk({name, "_data"}, res_data, exp);
      chk({name, "_tag"}, res_tag, tag);
      tick();
      chk({name, "_idle"}, {res_valid, req_ready}, 2'b01);
   endtask

   initial begin
      int lat, seen;
      rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_uop = '0;
      rs1 = '0; rs2 = '0; req_tag = '0; res_ready = 1'b1;
      tick(); tick();
      chk("rst_valid", res_valid, 1'b0);
      chk("rst_data",  res_data,  32'd0);
      chk("rst_tag",   res_tag,   6'd0);
      chk("rst_ready", req_ready, 1'b0);
      rst = 1'b0;
      #1;

      run_op("mul",    3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 6'd1,  32'hFFFF_FFEB, 2);
      run_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd2,  32'hFFFF_FFFE, 2);
      run_op("mulh",   3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd3,  32'h0000_0000, 2);
      run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd4,  32'hFFFF_FFFF, 2);
      run_op("div",    3'd4, 32'hFFFF_FFF9, 32'd2,         6'd5,  32'hFFFF_FFFD, 34);
      run_op("rem",    3'd6, 32'hFFFF_FFF9, 32'd2,         6'd6,  32'hFFFF_FFFF, 34);
      run_op("divu",   3'd5, 32'd100,       32'd7,         6'd7,  32'd14,        34);
      run_op("remu",   3'd7, 32'd100,       32'd7,         6'd8,  32'd2,         34);
      run_op("div0",   3'd4, 32'd5,         32'd0,         6'd9,  32'hFFFF_FFFF, 1);
      run_op("rem0",   3'd6, 32'd5,         32'd0,         6'd10, 32'd5,         1);
      run_op("divov",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 6'd11, 32'h8000_0000, 1);
      run_op("remov",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 6'd12, 32'd0,         1);

      // Backpressure: result held, no new accept while res_ready is low.
      res_ready = 1'b0;
      issue(3'd0, 32'd6, 32'd7, 6'd20);
      wait_valid(lat);
      chk("bp_lat", lat, 2);
      req_valid = 1'b1; req_uop = 7'd0; rs1 = 32'd1; rs2 = 32'd1; req_tag = 6'd21;
      for (int i = 0; i < 10; i++) begin
         chk("bp_data",  res_data,  32'd42);
         chk("bp_tag",   res_tag,   6'd20);
         chk("bp_ready", req_ready, 1'b0);
         tick();
      end
      req_valid = 1'b0;
      res_ready = 1'b1;
      chk("bp_valid", res_valid, 1'b1);
      tick();
      chk("bp_after", {res_valid, req_ready}, 2'b01);
      tick();
      chk("bp_noacc", {res_valid, req_ready}, 2'b01);

      // Flush during the 10th divide iteration.
      issue(3'd4, 32'd1000, 32'd3, 6'd30);
      for (int i = 0; i < 9; i++) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("fl_idle", {res_valid, req_ready}, 2'b01);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (res_valid) seen++;
         tick();
      end
      chk("fl_nores", seen, 0);
      run_op("fl_mul", 3'd0, 32'd9, 32'd9, 6'd31, 32'd81, 2);

      // Reset while a result sits in DONE.
      res_ready = 1'b0;
      issue(3'd0, 32'd3, 32'd5, 6'd40);
      wait_valid(lat);
      chk("rd_valid", res_valid, 1'b1);
      rst = 1'b1;
      tick();
      chk("rd_inrst", {res_valid, req_ready}, 2'b00);
      rst = 1'b0;
      #1;
      chk("rd_after", {res_valid, req_ready}, 2'b01);
      res_ready = 1'b1;
      tick();
      chk("rd_quiet", res_valid, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
